uart_tx_serializer: RTL and testbench

Serial transmit stage for the Nexys4DDR UART path. It accepts one parallel byte per handshake from the UART control FSM and drives it onto TXD as an 8N1 frame at 115200 baud from the 100 MHz board clock. It then returns a single-cycle completion pulse so the controller can advance to the next byte. It sits directly between the byte-sequencing controller and the FPGA TXD pin.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_tick.sv | 42 ++++
 rtl/uart_tx_serializer.sv | 112 +++++++++++
 tb/tb_uart_tx_serializer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding and 100 MHz / 115200 baud constants.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } uart_state_e;

    localparam int CLK_FREQ_HZ     = 100_000_000;
    localparam int BAUD_115200     = 115200;
    localparam int BAUD_DIV_115200 = CLK_FREQ_HZ / BAUD_115200;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: one-cycle tick on the last cycle of each BAUD_DIV-cycle period.
// Synchronous clear wins over enable; shared by the transmit and receive paths.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_115200
) (
    input  logic CLK100MHZ,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int              CW   = $clog2(BAUD_DIV);
    localparam logic [CW-1:0]   LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick = en && (cnt_q == LAST);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 transmit serializer: byte accepted on TXEN in IDLE, TXD low on that edge, DONE pulse
// BAUD_DIV*(DATA_WIDTH+2) cycles later; TXEN is ignored until the cycle after DONE.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_DIV   = BAUD_DIV_115200
) (
    input  logic                  CLK100MHZ,
    input  logic                  reset,
    input  logic                  TXEN,
    input  logic [DATA_WIDTH-1:0] DATA,
    output logic                  TXD,
    output logic                  DONE,
    output logic                  BUSY
);

    localparam int             IW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IW-1:0]  LAST_BIT = IW'(DATA_WIDTH - 1);

    uart_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [IW-1:0]         bit_idx_q, bit_idx_d;
    logic                  txd_q, txd_d;
    logic                  baud_clr;
    logic                  baud_en;
    logic                  baud_tick;

    uart_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .clr       (baud_clr),
        .en        (baud_en),
        .tick      (baud_tick)
    );

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            txd_q     <= txd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        txd_d     = txd_q;
        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (TXEN) begin
                    shreg_d   = DATA;
                    bit_idx_d = '0;
                    txd_d     = 1'b0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    txd_d   = shreg_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (bit_idx_q == LAST_BIT) begin
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        // TXD is registered, so it takes the bit that the shift exposes
                        shreg_d   = shreg_q >> 1;
                        bit_idx_d = bit_idx_q + 1'b1;
                        txd_d     = shreg_d[0];
                    end
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                txd_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                txd_d   = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        TXD      = txd_q;
        DONE     = (state_q == S_DONE);
        BUSY     = (state_q != S_IDLE);
        baud_en  = state_q inside {S_START, S_DATA, S_STOP};
        // Every state entry restarts the bit period; IDLE keeps it parked at zero
        baud_clr = (state_d != state_q) || (state_q == S_IDLE);
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: frame-timing model plus UART line decoder and directed cases.
module tb_uart_tx_serializer;

    localparam int BD = 868;
    localparam int W  = 8;
    localparam int FR = BD * (W + 2);

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       txen0 = 1'b0;
    logic       txen1 = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic       txd0, done0, busy0;
    logic       txd1, done1, busy1;

    always #5 clk = ~clk;

    uart_tx_serializer #(.DATA_WIDTH(8), .BAUD_DIV(BD)) dut0 (
        .CLK100MHZ (clk),
        .reset     (reset),
        .TXEN      (txen0),
        .DATA      (data0),
        .TXD       (txd0),
        .DONE      (done0),
        .BUSY      (busy0)
    );

    uart_tx_serializer #(.DATA_WIDTH(8), .BAUD_DIV(4)) dut1 (
        .CLK100MHZ (clk),
        .reset     (reset),
        .TXEN      (txen1),
        .DATA      (data1),
        .TXD       (txd1),
        .DONE      (done1),
        .BUSY      (busy1)
    );

    // Frame model: remembers the accepting edge and byte; outputs follow from elapsed cycles.
    int         cyc      = 0;
    bit         m_active = 1'b0;
    int         m_e0     = 0;
    logic [7:0] m_byte   = 8'h00;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (txen0 && (!m_active || (cyc + 1 - m_e0) >= FR + 2)) begin
                m_active <= 1'b1;
                m_e0     <= cyc + 1;
                m_byte   <= data0;
            end
        end
    end

    // Returns {TXD, DONE, BUSY} expected t cycles after the accepting edge.
    function automatic logic [2:0] model_out(input bit act, input int t, input logic [7:0] b);
        logic [7:0] sh;
        if (!act || t > FR) return 3'b100;
        if (t == FR)        return 3'b111;
        if (t < BD)         return 3'b001;
        if (t < BD * (W + 1)) begin
            sh = b >> (t / BD - 1);
            return {sh[0], 2'b01};
        end
        return 3'b101;
    endfunction

    // Line decoder: samples mid-bit after a falling start edge; pushes {stop, byte}.
    int         mon_t    = 0;
    bit         mon_busy = 1'b0;
    logic [7:0] mon_sh   = 8'h00;
    logic [8:0] mon_q[$];
    int         done_cycles[$];

    always @(negedge clk) begin
        if (done0) done_cycles.push_back(cyc);
        if (reset) begin
            mon_busy <= 1'b0;
        end else if (!mon_busy) begin
            if (!txd0) begin
                mon_busy <= 1'b1;
                mon_t    <= 1;
            end
        end else begin
            mon_t <= mon_t + 1;
            if (mon_t == 9 * BD + BD / 2) begin
                mon_q.push_back({txd0, mon_sh});
                mon_busy <= 1'b0;
            end else if (mon_t >= BD + BD / 2 && (mon_t - BD / 2) % BD == 0) begin
                mon_sh[3'((mon_t - BD / 2) / BD - 1)] <= txd0;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        logic [2:0] e;
        @(negedge clk);
        #1;
        if (!reset) begin
            e = model_out(m_active, cyc - m_e0, m_byte);
            check("per_cycle_txd_done_busy", 32'({txd0, done0, busy0}), 32'(e));
        end
    endtask

    task automatic tick_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic wait_done(output bit ok, input int budget);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic check_decoded(input string name, input int idx, input logic [7:0] b);
        if (mon_q.size() > idx) check(name, 32'(mon_q[idx]), 32'({1'b1, b}));
        else                    check(name, 32'(mon_q.size()), 32'(idx + 1));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        int         e0, nd, mq;
        logic [9:0] seq;
        logic [7:0] bytes [4];
        logic [2:0] exp3;

        seq   = 10'b1101000010;
        bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

        repeat (3) tick();
        check("reset_txd0",  32'(txd0),  32'(1'b1));
        check("reset_done0", 32'(done0), 32'(1'b0));
        check("reset_busy0", 32'(busy0), 32'(1'b0));
        check("reset_txd1",  32'(txd1),  32'(1'b1));
        check("reset_busy1", 32'(busy1), 32'(1'b0));
        reset = 1'b0;
        repeat (2) tick();

        // Single byte, TXEN held until DONE
        data0 = 8'hA1; txen0 = 1'b1; e0 = cyc + 1; nd = done_cycles.size(); mq = mon_q.size();
        for (int n = 0; n < 10; n++) begin
            tick_until(e0 + BD * n + BD / 2);
            check("a1_bit_value", 32'(txd0), 32'(seq[n]));
        end
        wait_done(ok, 2000);
        txen0 = 1'b0;
        check("a1_done_seen", 32'(ok), 32'(1'b1));
        check("a1_done_cycle", ok ? 32'(cyc) : 32'hffff_ffff, 32'(e0 + 8680));
        repeat (5) tick();
        check("a1_done_count", 32'(done_cycles.size() - nd), 32'(1));
        check_decoded("a1_decoded", mq, 8'hA1);

        // Controller-style back-to-back sequence
        nd = done_cycles.size(); mq = mon_q.size();
        data0 = bytes[0]; txen0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_done(ok, FR + 100);
            check("ctrl_done_seen", 32'(ok), 32'(1'b1));
            txen0 = 1'b0;
            tick();
            if (i < 3) begin
                data0 = bytes[i + 1];
                txen0 = 1'b1;
            end
        end
        repeat (3) tick();
        check("ctrl_done_count", 32'(done_cycles.size() - nd), 32'(4));
        check("ctrl_frame_count", 32'(mon_q.size() - mq), 32'(4));
        for (int i = 0; i < 4; i++) check_decoded("ctrl_decoded", mq + i, bytes[i]);
        for (int i = 0; i < 3; i++) begin
            if (done_cycles.size() > nd + i + 1)
                check("ctrl_frame_spacing", 32'(done_cycles[nd + i + 1] - done_cycles[nd + i]), 32'(8682));
            else
                check("ctrl_frame_spacing_missing", 32'(done_cycles.size()), 32'(nd + i + 2));
        end

        // DATA change and TXEN drop during data bit 3
        nd = done_cycles.size(); mq = mon_q.size();
        data0 = 8'h55; txen0 = 1'b1; e0 = cyc + 1;
        tick_until(e0 + 4 * BD);
        data0 = 8'hFF; txen0 = 1'b0;
        wait_done(ok, FR);
        check("chg_done_seen", 32'(ok), 32'(1'b1));
        repeat (3) tick();
        check_decoded("chg_decoded", mq, 8'h55);

        // Reset during data bit 4 of 8'h00, then a clean frame
        data0 = 8'h00; txen0 = 1'b1; e0 = cyc + 1; nd = done_cycles.size();
        tick_until(e0 + 5 * BD + 100);
        txen0 = 1'b0;
        check("pre_reset_busy", 32'(busy0), 32'(1'b1));
        #2 reset = 1'b1;
        #1;
        check("midrst_txd",  32'(txd0),  32'(1'b1));
        check("midrst_done", 32'(done0), 32'(1'b0));
        check("midrst_busy", 32'(busy0), 32'(1'b0));
        tick(); tick();
        reset = 1'b0;
        repeat (20) tick();
        check("midrst_no_done", 32'(done_cycles.size() - nd), 32'(0));
        mq = mon_q.size();
        data0 = 8'h3C; txen0 = 1'b1;
        wait_done(ok, FR + 100);
        txen0 = 1'b0;
        check("post_rst_done_seen", 32'(ok), 32'(1'b1));
        repeat (3) tick();
        check("post_rst_done_count", 32'(done_cycles.size() - nd), 32'(1));
        check_decoded("post_rst_decoded", mq, 8'h3C);

        // BAUD_DIV=4 instance, byte 8'h80: 40-cycle frame, DONE at E0+40
        data1 = 8'h80; txen1 = 1'b1; e0 = cyc + 1;
        for (int t = 0; t < 42; t++) begin
            tick_until(e0 + t);
            exp3 = {(t >= 32) ? 1'b1 : 1'b0, (t == 40) ? 1'b1 : 1'b0, (t <= 40) ? 1'b1 : 1'b0};
            check("bd4_txd_done_busy", 32'({txd1, done1, busy1}), 32'(exp3));
            if (t == 40) txen1 = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
